// File: rtl/blit_pkg.sv
// Shared definitions for the blitter fill engine:
// opcodes, command field layout and FSM state encoding.
package blit_pkg;

  localparam int CMD_W  = 104;
  localparam int FLD_W  = 16;
  localparam int ARG_W  = 32;

  localparam int OP_LSB  = 96;
  localparam int X_LSB   = 80;
  localparam int Y_LSB   = 64;
  localparam int W_LSB   = 48;
  localparam int H_LSB   = 32;
  localparam int ARG_LSB = 0;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_SET_BASE   = 8'h01;
  localparam logic [7:0] OP_SET_STRIDE = 8'h02;
  localparam logic [7:0] OP_FILL       = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FILL
  } state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Destination address generator: base/stride registers,
// rectangle walk counters and the write address.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEFAULT_STRIDE = 640
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_base,
  input  logic              set_stride,
  input  logic [ARG_W-1:0]  arg,
  input  logic              load,
  input  logic [FLD_W-1:0]  dst_x,
  input  logic [FLD_W-1:0]  dst_y,
  input  logic [FLD_W-1:0]  width,
  input  logic [FLD_W-1:0]  height,
  input  logic              step,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_pixel
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] start;
  logic [FLD_W-1:0]  stride;
  logic [FLD_W-1:0]  col;
  logic [FLD_W-1:0]  row;
  logic [FLD_W-1:0]  w_last;
  logic [FLD_W-1:0]  h_last;
  logic [31:0]       prod;

  assign prod  = 32'(dst_y) * 32'(stride);
  assign start = base + ADDR_W'(prod)
               + ADDR_W'(dst_x);

  assign last_pixel = (col == w_last)
                   && (row == h_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base     <= '0;
      stride   <= 16'(DEFAULT_STRIDE);
      row_addr <= '0;
      wr_addr  <= '0;
      col      <= '0;
      row      <= '0;
      w_last   <= '0;
      h_last   <= '0;
    end else begin
      if (set_base)
        base <= ADDR_W'(arg);
      if (set_stride)
        stride <= arg[FLD_W-1:0];
      if (load) begin
        row_addr <= start;
        wr_addr  <= start;
        col      <= '0;
        row      <= '0;
        w_last   <= width - 16'd1;
        h_last   <= height - 16'd1;
      end else if (step && !last_pixel) begin
        if (col != w_last) begin
          col     <= col + 16'd1;
          wr_addr <= wr_addr + ADDR_W'(1);
        end else begin
          col      <= '0;
          row      <= row + 16'd1;
          row_addr <= row_addr + ADDR_W'(stride);
          wr_addr  <= row_addr + ADDR_W'(stride);
        end
      end
    end
  end

endmodule

// File: rtl/blit_fill_engine.sv
// First blitter execution stage: pops commands, applies
// register ops and streams FILL pixels to the write port.
module blit_fill_engine
  import blit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEFAULT_STRIDE = 640
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_cmd,
  input  logic              cmd_valid,
  output logic              cmd_next,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              error,
  input  logic              err_clear,
  output logic [15:0]       fill_count
);

  state_t           state;
  logic [CMD_W-1:0] cmd_q;
  logic [7:0]       op;
  logic [FLD_W-1:0] dst_x;
  logic [FLD_W-1:0] dst_y;
  logic [FLD_W-1:0] width;
  logic [FLD_W-1:0] height;
  logic [ARG_W-1:0] arg;
  logic             in_decode;
  logic             is_reg;
  logic             is_fill;
  logic             empty;
  logic             step;
  logic             last_pixel;

  assign op     = cmd_q[OP_LSB +: 8];
  assign dst_x  = cmd_q[X_LSB +: FLD_W];
  assign dst_y  = cmd_q[Y_LSB +: FLD_W];
  assign width  = cmd_q[W_LSB +: FLD_W];
  assign height = cmd_q[H_LSB +: FLD_W];
  assign arg    = cmd_q[ARG_LSB +: ARG_W];

  assign in_decode = (state == S_DECODE);
  assign is_reg    = (op == OP_NOP)
                  || (op == OP_SET_BASE)
                  || (op == OP_SET_STRIDE);
  assign is_fill   = (op == OP_FILL);
  assign empty     = (width == '0) || (height == '0);
  assign step      = wr_valid && wr_ready;
  assign busy      = (state != S_IDLE);

  blit_addr_gen #(
    .ADDR_W         (ADDR_W),
    .DEFAULT_STRIDE (DEFAULT_STRIDE)
  ) u_addr (
    .clock      (clock),
    .reset      (reset),
    .set_base   (in_decode && op == OP_SET_BASE),
    .set_stride (in_decode && op == OP_SET_STRIDE),
    .arg        (arg),
    .load       (in_decode && is_fill && !empty),
    .dst_x      (dst_x),
    .dst_y      (dst_y),
    .width      (width),
    .height     (height),
    .step       (step),
    .wr_addr    (wr_addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      cmd_next   <= 1'b0;
      wr_valid   <= 1'b0;
      wr_data    <= '0;
      error      <= 1'b0;
      fill_count <= '0;
    end else begin
      cmd_next <= 1'b0;
      if (err_clear)
        error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state    <= S_FETCH;
            cmd_next <= 1'b1;
          end
        end
        S_FETCH: begin
          cmd_q <= cmd_cmd;
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_IDLE;
          unique case (1'b1)
            is_reg: ;
            is_fill && empty:
              fill_count <= fill_count + 16'd1;
            is_fill && !empty: begin
              state    <= S_FILL;
              wr_valid <= 1'b1;
              wr_data  <= arg[7:0];
            end
            default: error <= 1'b1;
          endcase
        end
        S_FILL: begin
          if (step && last_pixel) begin
            wr_valid   <= 1'b0;
            fill_count <= fill_count + 16'd1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_fill_engine.sv
// Bench for blit_fill_engine: FIFO feeder, rectangle
// model with per-beat compare, and directed scenarios.
module tb_blit_fill_engine;
  import blit_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [103:0] cmd_cmd = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_next;
  logic         wr_valid;
  logic         wr_ready = 1'b1;
  logic [31:0]  wr_addr;
  logic [7:0]   wr_data;
  logic         busy;
  logic         error;
  logic         err_clear = 1'b0;
  logic [15:0]  fill_count;

  always #5 clock = ~clock;

  blit_fill_engine #(
    .ADDR_W(32),
    .DEFAULT_STRIDE(640)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_cmd    (cmd_cmd),
    .cmd_valid  (cmd_valid),
    .cmd_next   (cmd_next),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .error      (error),
    .err_clear  (err_clear),
    .fill_count (fill_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // bench-side state: FIFO, model, observed beats
  logic [103:0] fifo[$];
  logic [31:0]  m_base   = 32'd0;
  logic [15:0]  m_stride = 16'd640;
  logic [15:0]  m_fc     = 16'd0;
  logic         m_err    = 1'b0;
  logic [31:0]  exp_addr[$];
  logic [7:0]   exp_data[$];
  logic [31:0]  got_addr[$];
  logic [7:0]   got_data[$];
  logic         toggle = 1'b0;
  logic [3:0]   pat = 4'b1001;
  int           n_stall = 0;

  function automatic logic [103:0] mk(
    input logic [7:0] op, input logic [15:0] x,
    input logic [15:0] y, input logic [15:0] w,
    input logic [15:0] h, input logic [31:0] arg);
    return {op, x, y, w, h, arg};
  endfunction

  task automatic push(input logic [103:0] c);
    logic [7:0]  op;
    logic [31:0] x, y, w, h, arg, a;
    op  = c[103:96];
    x   = 32'(c[95:80]);
    y   = 32'(c[79:64]);
    w   = 32'(c[63:48]);
    h   = 32'(c[47:32]);
    arg = c[31:0];
    fifo.push_back(c);
    case (op)
      8'h00: ;
      8'h01: m_base = arg;
      8'h02: m_stride = arg[15:0];
      8'h03: begin
        for (int r = 0; r < int'(h); r++)
          for (int k = 0; k < int'(w); k++) begin
            a = m_base + (y + 32'(r)) * 32'(m_stride)
              + x + 32'(k);
            exp_addr.push_back(a);
            exp_data.push_back(arg[7:0]);
          end
        m_fc = m_fc + 16'd1;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  // FIFO with registered head: pops on the edge after cmd_next
  initial begin
    logic p;
    int   tc;
    tc = 0;
    forever begin
      @(negedge clock);
      p = cmd_next;
      @(posedge clock);
      #1;
      if (p && fifo.size() > 0)
        void'(fifo.pop_front());
      cmd_valid = (fifo.size() > 0);
      cmd_cmd   = (fifo.size() > 0) ? fifo[0] : '0;
      tc++;
      wr_ready  = toggle ? pat[tc % 4] : 1'b1;
    end
  end

  // per-cycle compare against the model
  initial begin
    int          cyc;
    int          last_next;
    logic        stalled;
    logic [31:0] s_addr;
    logic [7:0]  s_data;
    cyc = 0;
    last_next = -1;
    stalled = 1'b0;
    s_addr = '0;
    s_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        stalled   = 1'b0;
        last_next = -1;
      end else begin
        if (cmd_next) begin
          if (last_next >= 0)
            check("next_gap", 64'(cyc - last_next >= 3), 1);
          last_next = cyc;
        end
        if (stalled) begin
          check("hold_valid", wr_valid, 1);
          check("hold_addr", wr_addr, s_addr);
          check("hold_data", wr_data, s_data);
        end
        stalled = wr_valid && !wr_ready;
        s_addr  = wr_addr;
        s_data  = wr_data;
        if (stalled) n_stall++;
        if (wr_valid && wr_ready) begin
          got_addr.push_back(wr_addr);
          got_data.push_back(wr_data);
          if (exp_addr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_write: got addr %0h, none expected",
                     wr_addr);
          end else begin
            check("beat_addr", wr_addr, exp_addr.pop_front());
            check("beat_data", wr_data, exp_data.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int stable;
    stable = 0;
    for (int i = 0; i < 3000 && stable < 4; i++) begin
      @(negedge clock);
      if (fifo.size() == 0 && !cmd_valid && !busy)
        stable++;
      else
        stable = 0;
    end
    check("idle_reached", 64'(stable >= 4), 1);
    check("exp_drained", exp_addr.size(), 0);
  endtask

  task automatic check_addrs(input string name, input int g0,
                             input int n,
                             input logic [31:0] ex[8]);
    check(name, got_addr.size() - g0, n);
    for (int i = 0; i < n; i++)
      if (g0 + i < got_addr.size())
        check(name, got_addr[g0+i], ex[i]);
  endtask

  initial begin
    logic [31:0] ex[8];
    int          g0;
    logic [15:0] fc0;

    repeat (3) @(negedge clock);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_cmd_next", cmd_next, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_fill_count", fill_count, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // basic fill with default stride
    g0 = got_addr.size();
    push(mk(8'h03, 16'd2, 16'd1, 16'd3, 16'd2, 32'hAA));
    wait_idle();
    ex = '{32'd642, 32'd643, 32'd644, 32'd1282,
           32'd1283, 32'd1284, 32'd0, 32'd0};
    check_addrs("t1_addr", g0, 6, ex);
    if (got_data.size() > g0)
      check("t1_data", got_data[g0], 8'hAA);
    check("t1_busy", busy, 0);
    check("t1_fill_count", fill_count, 1);
    check("t1_fc_model", fill_count, m_fc);

    // back-to-back register ops then fill
    g0 = got_addr.size();
    push(mk(8'h01, 0, 0, 0, 0, 32'h1000));
    push(mk(8'h02, 0, 0, 0, 0, 32'd16));
    push(mk(8'h03, 0, 0, 16'd2, 16'd2, 32'h55));
    wait_idle();
    ex = '{32'h1000, 32'h1001, 32'h1010, 32'h1011,
           32'd0, 32'd0, 32'd0, 32'd0};
    check_addrs("t2_addr", g0, 4, ex);
    check("t2_fill_count", fill_count, 2);

    // stalled write port
    g0 = got_addr.size();
    n_stall = 0;
    toggle = 1'b1;
    push(mk(8'h03, 0, 0, 16'd4, 16'd1, 32'h77));
    wait_idle();
    toggle = 1'b0;
    ex = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
           32'd0, 32'd0, 32'd0, 32'd0};
    check_addrs("t3_addr", g0, 4, ex);
    check("t3_stalls_seen", 64'(n_stall > 0), 1);

    // empty fill and unknown opcode
    g0 = got_addr.size();
    fc0 = fill_count;
    push(mk(8'h03, 0, 0, 16'd0, 16'd5, 32'h12));
    push(mk(8'h7F, 0, 0, 16'd1, 16'd1, 32'h0));
    wait_idle();
    check("t4_no_write", got_addr.size() - g0, 0);
    check("t4_fill_count", fill_count, fc0 + 16'd1);
    check("t4_error", error, 1);
    check("t4_err_model", error, m_err);
    @(negedge clock);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    m_err = 1'b0;
    check("t4_error_clr", error, 0);

    // address wrap
    g0 = got_addr.size();
    push(mk(8'h01, 0, 0, 0, 0, 32'hFFFF_FFFE));
    push(mk(8'h03, 0, 0, 16'd4, 16'd1, 32'h99));
    wait_idle();
    ex = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1,
           32'd0, 32'd0, 32'd0, 32'd0};
    check_addrs("t5_addr", g0, 4, ex);

    // reset in the middle of a fill
    g0 = got_addr.size();
    push(mk(8'h03, 0, 0, 16'd8, 16'd4, 32'h11));
    for (int i = 0; i < 200 && got_addr.size() < g0 + 3; i++)
      @(negedge clock);
    check("t6_started", 64'(got_addr.size() >= g0 + 3), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_wr_valid_async", wr_valid, 0);
    check("t6_busy_async", busy, 0);
    check("t6_fill_count", fill_count, 0);
    exp_addr.delete();
    exp_data.delete();
    m_base = 32'd0;
    m_stride = 16'd640;
    m_fc = 16'd0;
    m_err = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    g0 = got_addr.size();
    push(mk(8'h03, 16'd1, 16'd1, 16'd2, 16'd1, 32'h33));
    wait_idle();
    ex = '{32'd641, 32'd642, 32'd0, 32'd0,
           32'd0, 32'd0, 32'd0, 32'd0};
    check_addrs("t6_addr", g0, 2, ex);
    if (got_data.size() > g0)
      check("t6_data", got_data[g0], 8'h33);
    check("t6_fc_after", fill_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blit_fill_engine.md
Name: blit_fill_engine

Overview:
Consumes blitter commands from the blitter command FIFO on the downstream side, one at a time, and decodes them. Register-type commands update the destination base and stride. FILL commands become one byte-wide pixel write per cycle into the framebuffer write port. This is the first execution stage of the blitter; the memory arbiter sits downstream of it.

Parameters:
ADDR_W, 32, framebuffer byte-address width
DEFAULT_STRIDE, 640, stride in bytes after reset

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_cmd  in  104  command word from FIFO (registered, one cycle behind pointer)
cmd_valid  in  1  FIFO non-empty
cmd_next  out  1  pop strobe to FIFO
wr_valid  out  1  pixel write request
wr_ready  in  1  memory accepts write
wr_addr  out  ADDR_W  byte address
wr_data  out  8  pixel colour
busy  out  1  state != IDLE
error  out  1  sticky: unknown opcode seen
err_clear  in  1  clears error
fill_count  out  16  completed FILL commands, wraps at 65535->0

Behaviour:
- Command fields: op[103:96], dst_x[95:80], dst_y[79:64], width[63:48], height[47:32], arg[31:0]. All fields unsigned.
- Opcodes: 0x00 NOP, 0x01 SET_BASE (base <= arg), 0x02 SET_STRIDE (stride <= arg[15:0]), 0x03 FILL (colour = arg[7:0]). Any other opcode: command discarded, error <= 1.
- Reset (reset=0, async): state IDLE; cmd_next, wr_valid, error = 0; wr_addr, wr_data, fill_count = 0; base = 0; stride = DEFAULT_STRIDE.
- A reset during FILL aborts it immediately. No partial-state recovery.
- FSM states: IDLE, FETCH, DECODE, FILL.
- IDLE: if cmd_valid, go to FETCH.
- FETCH: cmd_next=1 for exactly this cycle; latch cmd_cmd into the internal command register. Go to DECODE.
- DECODE: execute register ops and go to IDLE.
  - FILL with width=0 or height=0: fill_count++, no writes, go to IDLE.
  - Otherwise: row_addr <= base + dst_y*stride + dst_x, modulo 2^ADDR_W. wr_addr <= same value, col=0, row=0. Go to FILL.
- Pop spacing: DECODE is a mandatory gap, because FIFO data lags its pointer by one cycle. cmd_cmd is therefore never sampled earlier than 2 cycles after the cmd_next cycle. Maximum throughput is 1 command per 3 cycles.
- FILL: wr_valid=1, wr_data=colour.
  - On wr_valid&&wr_ready with col<width-1: col++, wr_addr++.
  - With col=width-1 and row<height-1: row++, col=0, row_addr += stride, wr_addr <= row_addr+stride.
  - With col=width-1 and row=height-1: wr_valid <= 0, fill_count++, go to IDLE.
- wr_addr and wr_data are held stable while wr_valid && !wr_ready. The beat fires in the same cycle ready is seen, so a fully ready port gives one pixel per cycle.
- Pixel count of a FILL is width*height. Address wraps modulo 2^ADDR_W with no clipping.
- error/err_clear: a new unknown opcode in the same cycle as err_clear leaves error=1 (set wins).
- cmd_valid dropping while in DECODE or FILL has no effect. The next pop waits until IDLE.

Decomposition:
- Package blit_pkg holds:
  - opcode constants OP_NOP, OP_SET_BASE, OP_SET_STRIDE, OP_FILL;
  - command field bit positions/widths;
  - state encoding for the FSM.
- One sub-module, blit_addr_gen:
  - holds base/stride/row_addr/col/row counters;
  - computes the start address with one 16x16 multiply;
  - produces wr_addr and last_pixel.
- The top level keeps the FSM, the FIFO handshake and the status outputs.

Test Plan:
- After reset, FILL x=2,y=1,w=3,h=2,colour=0xAA with wr_ready=1 and stride 640. Expect 6 writes at addr 642,643,644,1282,1283,1284, data 0xAA, then busy=0 and fill_count=1.
- SET_BASE 0x1000, SET_STRIDE 16, FILL x=0,y=0,w=2,h=2,col=0x55 queued back-to-back. Expect cmd_next pulses ≥3 cycles apart and writes at 0x1000,0x1001,0x1010,0x1011.
- wr_ready toggling 1,0,0,1,... during a 4-pixel FILL. Expect addr/data held while stalled and exactly 4 accepted beats in order.
- FILL with w=0 then opcode 0x7F. Expect no write, fill_count+1, error=1. err_clear pulse expects error=0.
- SET_BASE 0xFFFFFFFE then FILL x=0,w=4,h=1. Expect addrs FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Assert reset mid-FILL. Expect wr_valid=0 asynchronously, stride=640, and the next command is processed normally after release.
